// File: rtl/stream_acc_pkg.sv
// rtl/stream_acc_pkg.sv - shared types and helpers for the stream accumulator
package stream_acc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    sat_inc = (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/carry_skip_32bit_adder.sv
// rtl/carry_skip_32bit_adder.sv - 32-bit carry-skip adder, 4-bit ripple blocks
module carry_skip_32bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  always_comb begin : add_blk
    logic w_c;
    logic w_rc;
    logic w_bp;
    logic w_p;
    sum  = '0;
    w_c  = cin;
    w_rc = 1'b0;
    w_bp = 1'b0;
    w_p  = 1'b0;
    for (int g = 0; g < 8; g++) begin
      w_rc = w_c;
      w_bp = 1'b1;
      for (int k = 0; k < 4; k++) begin
        w_p             = a[g*4+k] ^ b[g*4+k];
        sum[g*4+k]      = w_p ^ w_rc;
        w_rc            = (a[g*4+k] & b[g*4+k]) | (w_p & w_rc);
        w_bp            = w_bp & w_p;
      end
      // A fully propagating block passes its carry-in straight through.
      w_c = w_bp ? w_c : w_rc;
    end
    cout = w_c;
  end

endmodule

// File: rtl/stream_accumulator_32.sv
// rtl/stream_accumulator_32.sv - per-packet add/sub accumulator with one-entry result register
module stream_accumulator_32
  import stream_acc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  acc_state_t        r_state;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_acc;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_sum;
  logic [CNT_W-1:0]  r_out_count;
  logic              r_out_ovf;

  logic              w_accept;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_sum;
  logic              w_cout;
  logic              w_flag;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_a    = (r_state == IDLE) ? '0 : r_acc;
  assign w_b    = in_sub ? ~in_data : in_data;
  // Subtraction is a + ~b + 1, so a missing carry-out means a borrow.
  assign w_flag = in_sub ? !w_cout : w_cout;
  assign w_cnt_nxt = CNT_W'(sat_inc(32'(r_cnt), 32'({CNT_W{1'b1}})));

  carry_skip_32bit_adder u_add (
    .a    (w_a),
    .b    (w_b),
    .cin  (in_sub),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (in_last) begin
          r_out_sum   <= w_sum;
          r_out_count <= w_cnt_nxt;
          r_out_ovf   <= r_ovf_acc | w_flag;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf_acc   <= 1'b0;
          r_state     <= IDLE;
        end else begin
          r_acc       <= w_sum;
          r_cnt       <= w_cnt_nxt;
          r_ovf_acc   <= r_ovf_acc | w_flag;
          r_state     <= ACCUM;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_stream_accumulator_32.sv
// tb/tb_stream_accumulator_32.sv - directed and random checks of stream_accumulator_32
module tb_stream_accumulator_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sub;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: running packet total and expected result register.
  longint unsigned m_acc;
  int              m_cnt;
  bit              m_ovf;
  logic [31:0]     e_sum;
  logic [31:0]     e_cnt;
  logic            e_ovf;

  stream_accumulator_32 #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic model_beat(input logic [31:0] d, input logic s, input logic l);
    longint unsigned v;
    bit              flag;
    if (s) begin
      flag = (longint'(d) > m_acc);
      v    = (m_acc - longint'(d)) & 64'hFFFF_FFFF;
    end else begin
      v    = m_acc + longint'(d);
      flag = (v > 64'hFFFF_FFFF);
      v    = v & 64'hFFFF_FFFF;
    end
    m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    m_ovf = m_ovf | flag;
    if (l) begin
      e_sum = v[31:0];
      e_cnt = 32'(m_cnt);
      e_ovf = m_ovf;
      model_reset();
    end else begin
      m_acc = v;
    end
  endtask

  // Present one beat starting off-edge and wait (bounded) for it to be taken.
  task automatic send(input logic [31:0] d, input logic s, input logic l);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    guard    = 0;
    #1;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    model_beat(d, s, l);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"},   out_sum,        e_sum);
    check({tag, "_count"}, 32'(out_count), e_cnt);
    check({tag, "_ovf"},   32'(out_ovf),   32'(e_ovf));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_sum"},   out_sum,        32'd0);
    check({tag, "_count"}, 32'(out_count), 32'd0);
    check({tag, "_ovf"},   32'(out_ovf),   32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    int len;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    model_reset();
    e_sum = '0;
    e_cnt = '0;
    e_ovf = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    send(32'd5, 1'b0, 1'b0);
    send(32'd7, 1'b0, 1'b0);
    check("latency_before_last", 32'(out_valid), 32'd0);
    send(32'd9, 1'b0, 1'b1);
    check("basic_const_sum", out_sum, 32'd21);
    check_result("basic");

    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b1);
    check("carry_const_sum", out_sum, 32'd1);
    check_result("carry");

    send(32'd10, 1'b0, 1'b0);
    send(32'd3, 1'b1, 1'b1);
    check("sub_const_sum", out_sum, 32'd7);
    check_result("sub");

    send(32'd1, 1'b1, 1'b1);
    check("borrow_const_sum", out_sum, 32'hFFFF_FFFF);
    check_result("borrow");

    // Hold the result: input must stall and the result must not move.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd99;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_result("stall_hold");
    @(posedge clk);
    #1;
    check_result("stall_hold2");
    out_ready = 1'b1;
    send(32'd42, 1'b0, 1'b1);
    check("replace_const_sum", out_sum, 32'd42);
    check_result("replace");

    for (int i = 0; i < 300; i++) send(32'd1, 1'b0, (i == 299));
    check("sat_const_count", 32'(out_count), 32'd255);
    check_result("sat");

    send(32'd1, 1'b0, 1'b0);
    send(32'd1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'd4, 1'b0, 1'b1);
    check("post_reset_sum", out_sum, 32'd4);
    check("post_reset_count", 32'(out_count), 32'd1);

    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send(($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000)),
             1'($urandom_range(0, 1)), (b == len - 1));
      end
      check_result("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
